pipe_adder: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor; the successor to the fixed 32-bit ripple full-adder.
- Operand width is split into STAGES equal slices. Each pipeline stage ripples one slice and registers its carry into the next stage.
- Results return through a valid/ready handshake, so the block can feed the ALU datapath at higher clock rates.
- Also produces carry, overflow and zero flags.

---
 rtl/pipe_adder_pkg.sv | 21 ++
 rtl/pipe_adder_slice.sv | 29 ++
 rtl/pipe_adder.sv | 146 ++++++++++++++
 tb/tb_pipe_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor (package adder_pkg).
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Width-independent part of a stage record; the operand and partial-sum
   // fields depend on WIDTH and live next to it in the top level.
   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

   function automatic int unsigned slice_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational W-bit ripple adder used as one pipeline stage of pipe_adder.
// c_msb_o is the carry entering the top bit, needed for signed overflow.
module adder_slice #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         c_i,
   output logic [W-1:0] sum_o,
   output logic         c_o,
   output logic         c_msb_o
);

   logic [W:0] w_c;

   // Ripple: each bit consumes the carry produced by the bit below it
   always_comb begin
      w_c[0] = c_i;
      sum_o  = '0;
      for (int i = 0; i < int'(W); i++) begin
         sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
         w_c[i+1]  = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign c_o     = w_c[W];
   assign c_msb_o = w_c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor with valid/ready output.
// WIDTH is split into STAGES slices; stage k adds slice k with the carry
// registered by stage k-1. Operands still to be added travel right-aligned
// through the pipe; finished slices are shifted in from the top of the sum
// so the last stage holds the fully deskewed result.
// Optional feature macro: PIPE_ADDER_FLAGS_EN (overflow_o / zero_o).
// Without it both flags are tied low.
module pipe_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             carry_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             zero_o
);

   localparam int unsigned SLICE = slice_width(WIDTH, STAGES);

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
   end

   op_e              w_op;
   logic             w_advance;
   logic [WIDTH-1:0] w_a_in     [STAGES];
   logic [WIDTH-1:0] w_b_in     [STAGES];
   logic [WIDTH-1:0] w_sum_in   [STAGES];
   logic             w_cin      [STAGES];
   logic             w_vin      [STAGES];
   logic [SLICE-1:0] w_slice_sum[STAGES];
   logic             w_cout     [STAGES];
   logic             w_cmsb     [STAGES];
   logic [WIDTH-1:0] w_sum_next [STAGES];
   logic             w_unused_cmsb;

   logic [WIDTH-1:0] r_sum [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   stage_ctl_t       r_ctl [STAGES];

   assign w_op      = sub_i ? OP_SUB : OP_ADD;
   assign w_advance = !r_ctl[STAGES-1].valid || ready_i;
   assign ready_o   = w_advance;
   assign valid_o   = r_ctl[STAGES-1].valid;
   assign sum_o     = r_sum[STAGES-1];
   assign carry_o   = r_ctl[STAGES-1].carry;

   // Stage inputs: stage 0 from the ports (B inverted for subtract), later stages from the previous stage
   always_comb begin
      w_a_in[0]   = a_i;
      w_b_in[0]   = (w_op == OP_SUB) ? ~b_i : b_i;
      w_cin[0]    = (w_op == OP_SUB) ? 1'b1 : carry_i;
      w_vin[0]    = valid_i;
      w_sum_in[0] = '0;
      for (int k = 1; k < int'(STAGES); k++) begin
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
         w_cin[k]    = r_ctl[k-1].carry;
         w_vin[k]    = r_ctl[k-1].valid;
         w_sum_in[k] = r_sum[k-1];
      end
   end

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      adder_slice #(.W(SLICE)) u_slice (
         .a_i    (w_a_in[k][SLICE-1:0]),
         .b_i    (w_b_in[k][SLICE-1:0]),
         .c_i    (w_cin[k]),
         .sum_o  (w_slice_sum[k]),
         .c_o    (w_cout[k]),
         .c_msb_o(w_cmsb[k])
      );
      assign w_sum_next[k] = (w_sum_in[k] >> SLICE)
                           | (WIDTH'(w_slice_sum[k]) << (WIDTH - SLICE));
   end

   // Only the final stage's MSB carry matters; the others are structurally unused
   always_comb begin
      w_unused_cmsb = 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
         w_unused_cmsb = w_unused_cmsb ^ w_cmsb[k];
      end
   end

   // Stage registers: global stall on !advance; data loads only for valid ops so outputs hold across bubbles
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            r_sum[k] <= '0;
            r_ctl[k] <= '0;
            if (k < int'(STAGES) - 1) begin
               r_a[k] <= '0;
               r_b[k] <= '0;
            end
         end
      end else if (w_advance) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            r_ctl[k].valid <= w_vin[k];
            if (w_vin[k]) begin
               r_sum[k]       <= w_sum_next[k];
               r_ctl[k].carry <= w_cout[k];
               if (k < int'(STAGES) - 1) begin
                  r_a[k] <= w_a_in[k] >> SLICE;
                  r_b[k] <= w_b_in[k] >> SLICE;
               end
            end
         end
      end
   end

`ifdef PIPE_ADDER_FLAGS_EN
   logic r_ovf;
   logic r_zero;

   // Flags from the final slice, registered in step with sum_o
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_advance && w_vin[STAGES-1]) begin
         r_ovf  <= w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
         r_zero <= (w_sum_next[STAGES-1] == '0);
      end
   end

   assign overflow_o = r_ovf;
   assign zero_o     = r_zero;
`else
   assign overflow_o = 1'b0;
   assign zero_o     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: the driver pushes expected results on
// acceptance, a negedge monitor pops and compares on every output handshake.
module tb_pipe_adder #(
   parameter int STAGES = 4
);

   localparam int WIDTH = 32;
`ifdef PIPE_ADDER_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk_i;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        sub_i;
   logic        carry_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] sum_o;
   logic        carry_o;
   logic        overflow_o;
   logic        zero_o;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t exp_q[$];
   exp_t e_mon;
   exp_t held;
   logic holding = 1'b0;
   bit   ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .a_i       (a_i),
      .b_i       (b_i),
      .sub_i     (sub_i),
      .carry_i   (carry_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .sum_o     (sum_o),
      .carry_o   (carry_o),
      .overflow_o(overflow_o),
      .zero_o    (zero_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference: plain integer arithmetic, signed overflow by range check
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic c);
      exp_t        e;
      longint      sa;
      longint      sb;
      longint      sr;
      logic [32:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         e.sum   = a - b;
         e.carry = (a >= b);
         sr      = sa - sb;
      end else begin
         t       = 33'(a) + 33'(b) + 33'(c);
         e.sum   = t[31:0];
         e.carry = t[32];
         sr      = sa + sb + longint'(c);
      end
      e.ovf  = FLAGS_EN && ((sr > 64'sd2147483647) || (sr < -64'sd2147483648));
      e.zero = FLAGS_EN && (e.sum == 32'd0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   // Monitor: pops and compares on every output handshake, checks hold during stall
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         holding = 1'b0;
      end else begin
         chk("ready_rule", 64'(ready_o), 64'(!valid_o || ready_i));
         if (valid_o) begin
            if (holding) begin
               chk("hold_sum", 64'(sum_o), 64'(held.sum));
               chk("hold_carry", 64'(carry_o), 64'(held.carry));
               chk("hold_ovf", 64'(overflow_o), 64'(held.ovf));
               chk("hold_zero", 64'(zero_o), 64'(held.zero));
            end
            if (ready_i) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got sum %0h, expected no output", sum_o);
               end else begin
                  e_mon = exp_q.pop_front();
                  chk("sum", 64'(sum_o), 64'(e_mon.sum));
                  chk("carry", 64'(carry_o), 64'(e_mon.carry));
                  chk("overflow", 64'(overflow_o), 64'(e_mon.ovf));
                  chk("zero", 64'(zero_o), 64'(e_mon.zero));
               end
               holding = 1'b0;
            end else begin
               holding = 1'b1;
               held    = '{sum_o, carry_o, overflow_o, zero_o};
            end
         end else begin
            holding = 1'b0;
         end
      end
   end

   // One cycle of stimulus, starting just after a rising edge
   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input logic rdy, output logic acc);
      valid_i = v;
      a_i     = a;
      b_i     = b;
      sub_i   = s;
      carry_i = c;
      ready_i = rdy;
      @(negedge clk_i);
      acc = v && ready_o;
      if (acc) exp_q.push_back(model(a, b, s, c));
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic c, input bit use_pat);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
         drive(1'b1, a, b, s, c, use_pat ? logic'(ready_pat[cyc % 4]) : 1'b1, acc);
         tries++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no accept after %0d cycles, expected accept", tries);
      end
   endtask

   task automatic measure_latency(input string name);
      int n;
      valid_i = 1'b0;
      ready_i = 1'b1;
      n = 1;
      while (!valid_o && n < 4 * STAGES + 8) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk(name, 64'(n), 64'(STAGES));
   endtask

   task automatic drain();
      int n;
      valid_i = 1'b0;
      ready_i = 1'b1;
      n = 0;
      while ((exp_q.size() != 0) && n < 4 * STAGES + 200) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic        c;
   } op_t;

   initial begin
      op_t  dir[6];
      logic acc;
      dir[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
      dir[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
      dir[2] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1};
      dir[3] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0};
      dir[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0};
      dir[5] = '{32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1};

      rst_ni  = 1'b0;
      valid_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      sub_i   = 1'b0;
      carry_i = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_valid", 64'(valid_o), 64'd0);
      chk("reset_sum", 64'(sum_o), 64'd0);
      chk("reset_carry", 64'(carry_o), 64'd0);
      chk("reset_ovf", 64'(overflow_o), 64'd0);
      chk("reset_zero", 64'(zero_o), 64'd0);
      chk("reset_ready", 64'(ready_o), 64'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      drive(1'b1, 32'd5, 32'd3, 1'b0, 1'b0, 1'b1, acc);
      chk("accept_first", 64'(acc), 64'd1);
      measure_latency("latency_cold");

      for (int i = 0; i < 6; i++) send(dir[i].a, dir[i].b, dir[i].s, dir[i].c, 1'b0);
      drain();

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(3) == 0) drive(1'b0, $urandom, $urandom, 1'b0, 1'b0,
                                           logic'(ready_pat[cyc % 4]), acc);
         send(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
      end
      drain();

      for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(1)), 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("async_reset_valid", 64'(valid_o), 64'd0);
      chk("async_reset_sum", 64'(sum_o), 64'd0);
      chk("async_reset_carry", 64'(carry_o), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      send(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
      measure_latency("latency_after_reset");
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
